// File: rtl/ipg_pkg.sv
// Shared constants and helpers for the IPG message insertion path.
package ipg_pkg;

  // 64b/66b sync headers.
  localparam logic [1:0]  SYNC_CTRL  = 2'b01;
  localparam logic [1:0]  SYNC_DATA  = 2'b10;

  // Payload of an all-idle control block (block type 0x1E, idle characters).
  localparam logic [63:0] IDLE_BLOCK = 64'h1E;

  // What the output stage does with the current input block.
  typedef enum logic [1:0] {
    BLK_PASS   = 2'd0,  // non-idle block, forwarded untouched
    BLK_IDLE   = 2'd1,  // idle block, nothing queued, forwarded untouched
    BLK_INSERT = 2'd2   // idle block replaced by one queued IPG word
  } blk_kind_e;

  // Width of a channel index; at least one bit even for a single channel.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/ipg_chan_fifo.sv
// Per-channel IPG word FIFO: no fall-through, push accepted when full if the
// same cycle pops, sticky overflow flag for dropped pushes.
module ipg_chan_fifo #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic              ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    occ;
  logic              do_push;
  logic              do_pop;

  assign full    = (occ == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (occ == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a word when its head leaves in the same cycle.
  assign do_push = push && !reset && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Word storage.
  // NOTE: the storage array has no reset; occupancy alone decides which
  // entries are valid, so clearing it would only cost a wide reset tree.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers, occupancy and sticky overflow; pointers wrap at FIFO_DEPTH.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (push && full && !do_pop) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/ipg_tx_arb.sv
// Replaces idle 64b/66b blocks with queued IPG message words. One block in,
// one block out per cycle, fixed one-cycle latency, never stalls.
module ipg_tx_arb
  import ipg_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int HDR_W      = 2,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int RR_EN      = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [HDR_W-1:0]         encoded_tx_hdr,
  input  logic [DATA_W-1:0]        encoded_tx_data,
  input  logic [NUM_CH-1:0]        ch_wr,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [HDR_W-1:0]         proced_encoded_tx_hdr,
  output logic [DATA_W-1:0]        proced_encoded_tx_data,
  output logic [NUM_CH-1:0]        ch_full,
  output logic [NUM_CH-1:0]        ch_empty,
  output logic [NUM_CH-1:0]        ch_ovf,
  output logic [31:0]              ins_cnt
);

  localparam int                CH_W      = ch_idx_w(NUM_CH);
  localparam logic [HDR_W-1:0]  IDLE_HDR  = HDR_W'(SYNC_CTRL);
  localparam logic [DATA_W-1:0] IDLE_DATA = DATA_W'(IDLE_BLOCK);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

  logic [DATA_W-1:0] head [NUM_CH];
  logic [NUM_CH-1:0] pop;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   cand;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_vld;
  logic              is_idle;
  blk_kind_e         kind;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    ipg_chan_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (ch_wr[k]),
      .pop   (pop[k]),
      .wdata (ch_data[k*DATA_W +: DATA_W]),
      .rdata (head[k]),
      .full  (ch_full[k]),
      .empty (ch_empty[k]),
      .ovf   (ch_ovf[k])
    );
  end

  assign is_idle = (encoded_tx_hdr == IDLE_HDR) && (encoded_tx_data == IDLE_DATA);

  // Pick the first non-empty channel in search order; walking the order
  // backwards lets the last hit (the earliest in order) win without a break.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = (RR_EN != 0) ? CH_W'((int'(rr_ptr) + i) % NUM_CH) : CH_W'(i);
      if (!ch_empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Classify the input block and pop the granted channel on insertion only.
  always_comb begin
    pop = '0;
    if (!is_idle)       kind = BLK_PASS;
    else if (grant_vld) kind = BLK_INSERT;
    else                kind = BLK_IDLE;
    if (kind == BLK_INSERT) pop[grant_idx] = 1'b1;
  end

  // Output block register, insertion counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      proced_encoded_tx_hdr  <= IDLE_HDR;
      proced_encoded_tx_data <= IDLE_DATA;
      ins_cnt                <= '0;
      rr_ptr                 <= '0;
    end else begin
      case (kind)
        BLK_INSERT: begin
          proced_encoded_tx_hdr  <= IDLE_HDR;
          proced_encoded_tx_data <= head[grant_idx];
          ins_cnt                <= ins_cnt + 32'd1;
          if (RR_EN != 0) rr_ptr <= (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
        end
        BLK_IDLE: begin
          proced_encoded_tx_hdr  <= IDLE_HDR;
          proced_encoded_tx_data <= IDLE_DATA;
        end
        default: begin
          proced_encoded_tx_hdr  <= encoded_tx_hdr;
          proced_encoded_tx_data <= encoded_tx_data;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ipg_tx_arb.sv
// Directed bench for ipg_tx_arb: a round-robin and a fixed-priority instance
// (two channels, depth 4) share one stimulus stream.
module tb_ipg_tx_arb;
  import ipg_pkg::*;

  localparam int DW = 64;
  localparam int HW = 2;
  localparam int NC = 2;
  localparam int FD = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [HW-1:0]  hdr;
  logic [DW-1:0]  data;
  logic [NC-1:0]  wr;
  logic [NC*DW-1:0] cdata;

  logic [HW-1:0]  a_hdr,  b_hdr;
  logic [DW-1:0]  a_data, b_data;
  logic [NC-1:0]  a_full, b_full, a_empty, b_empty, a_ovf, b_ovf;
  logic [31:0]    a_cnt,  b_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ipg_tx_arb #(.DATA_W(DW), .HDR_W(HW), .NUM_CH(NC), .FIFO_DEPTH(FD), .RR_EN(1)) dut_rr (
    .clk(clk), .reset(reset), .encoded_tx_hdr(hdr), .encoded_tx_data(data),
    .ch_wr(wr), .ch_data(cdata),
    .proced_encoded_tx_hdr(a_hdr), .proced_encoded_tx_data(a_data),
    .ch_full(a_full), .ch_empty(a_empty), .ch_ovf(a_ovf), .ins_cnt(a_cnt)
  );

  ipg_tx_arb #(.DATA_W(DW), .HDR_W(HW), .NUM_CH(NC), .FIFO_DEPTH(FD), .RR_EN(0)) dut_fp (
    .clk(clk), .reset(reset), .encoded_tx_hdr(hdr), .encoded_tx_data(data),
    .ch_wr(wr), .ch_data(cdata),
    .proced_encoded_tx_hdr(b_hdr), .proced_encoded_tx_data(b_data),
    .ch_full(b_full), .ch_empty(b_empty), .ch_ovf(b_ovf), .ins_cnt(b_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] h, input logic [63:0] d, input logic [1:0] w,
                       input logic [63:0] w0, input logic [63:0] w1);
    hdr   = h;
    data  = d;
    wr    = w;
    cdata = {w1, w0};
  endtask

  task automatic idle();
    drive(SYNC_CTRL, IDLE_BLOCK, 2'b00, 64'h0, 64'h0);
  endtask

  logic [63:0] exp_rr [6];
  logic [63:0] exp_fp [6];

  initial begin
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;

    // Reset state.
    check("rst_hdr",   a_hdr,   64'(SYNC_CTRL));
    check("rst_data",  a_data,  64'h1E);
    check("rst_full",  a_full,  64'h0);
    check("rst_empty", a_empty, 64'h3);
    check("rst_ovf",   a_ovf,   64'h0);
    check("rst_cnt",   a_cnt,   64'h0);

    // Pass-through of data blocks with empty FIFOs.
    for (int i = 0; i < 10; i++) begin
      drive(SYNC_DATA, 64'hD000 + 64'(i), 2'b00, 64'h0, 64'h0);
      step();
      check("pass_hdr",  a_hdr,  64'(SYNC_DATA));
      check("pass_data", a_data, 64'hD000 + 64'(i));
    end
    check("pass_cnt", a_cnt, 64'h0);

    // Single insertion on ch0.
    drive(SYNC_DATA, 64'hD0FF, 2'b01, 64'hA5A5_0000_0000_0001, 64'h0);
    step();
    check("ins_queued", a_empty, 64'h2);
    idle();
    step();
    check("ins_hdr",   a_hdr,   64'(SYNC_CTRL));
    check("ins_data",  a_data,  64'hA5A5_0000_0000_0001);
    check("ins_empty", a_empty, 64'h3);
    check("ins_cnt",   a_cnt,   64'h1);

    // Push into an empty FIFO during an idle: no same-cycle insertion.
    drive(SYNC_CTRL, IDLE_BLOCK, 2'b10, 64'h0, 64'hBEEF);
    step();
    check("nofall_data",  a_data,  64'h1E);
    check("nofall_cnt",   a_cnt,   64'h1);
    check("nofall_empty", a_empty, 64'h1);
    idle();
    step();
    check("nofall_next", a_data, 64'hBEEF);
    check("nofall_cnt2", a_cnt,  64'h2);

    // Arbitration: three words per channel, then six idles.
    for (int i = 0; i < 3; i++) begin
      drive(SYNC_DATA, 64'hD100 + 64'(i), 2'b11, 64'h100 + 64'(i), 64'h200 + 64'(i));
      step();
    end
    exp_rr = '{64'h100, 64'h200, 64'h101, 64'h201, 64'h102, 64'h202};
    exp_fp = '{64'h100, 64'h101, 64'h102, 64'h200, 64'h201, 64'h202};
    for (int i = 0; i < 6; i++) begin
      idle();
      step();
      check("rr_order", a_data, exp_rr[i]);
      check("fp_order", b_data, exp_fp[i]);
    end
    check("rr_cnt",   a_cnt,   64'd8);
    check("fp_cnt",   b_cnt,   64'd8);
    check("rr_empty", a_empty, 64'h3);

    // Overflow: five pushes into a depth-4 FIFO with no idles.
    for (int i = 0; i < 5; i++) begin
      drive(SYNC_DATA, 64'hD200 + 64'(i), 2'b10, 64'h0, 64'h300 + 64'(i));
      step();
    end
    check("ovf_full", a_full, 64'h2);
    check("ovf_flag", a_ovf,  64'h2);
    check("ovf_cnt",  a_cnt,  64'd8);
    for (int i = 0; i < 5; i++) begin
      idle();
      step();
      check("ovf_drain", a_data, (i < 4) ? 64'h300 + 64'(i) : 64'h1E);
    end
    check("ovf_cnt2",  a_cnt,  64'd12);
    check("ovf_stick", a_ovf,  64'h2);

    // Push while full with a simultaneous pop of the same channel.
    for (int i = 0; i < 4; i++) begin
      drive(SYNC_DATA, 64'hD300 + 64'(i), 2'b01, 64'h400 + 64'(i), 64'h0);
      step();
    end
    check("fp_full0", a_full, 64'h1);
    drive(SYNC_CTRL, IDLE_BLOCK, 2'b01, 64'h77, 64'h0);
    step();
    check("pp_head",  a_data, 64'h400);
    check("pp_full",  a_full, 64'h1);
    check("pp_ovf",   a_ovf,  64'h2);
    for (int i = 0; i < 4; i++) begin
      idle();
      step();
      check("pp_drain", a_data, (i < 3) ? 64'h401 + 64'(i) : 64'h77);
    end
    check("pp_empty", a_empty, 64'h3);
    check("pp_cnt",   a_cnt,   64'd17);

    // Reset mid-drain, with pushes presented during reset.
    for (int i = 0; i < 3; i++) begin
      drive(SYNC_DATA, 64'hD400 + 64'(i), 2'b01, 64'h500 + 64'(i), 64'h0);
      step();
    end
    drive(SYNC_CTRL, IDLE_BLOCK, 2'b11, 64'h600, 64'h601);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    check("mrst_hdr",   a_hdr,   64'(SYNC_CTRL));
    check("mrst_data",  a_data,  64'h1E);
    check("mrst_empty", a_empty, 64'h3);
    check("mrst_full",  a_full,  64'h0);
    check("mrst_ovf",   a_ovf,   64'h0);
    check("mrst_cnt",   a_cnt,   64'h0);
    check("mrst_cnt_b", b_cnt,   64'h0);
    step();
    check("mrst_next",  a_data,  64'h1E);
    check("mrst_cnt2",  a_cnt,   64'h0);
    check("mrst_emp2",  a_empty, 64'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ipg_tx_arb.md
IPG_TX_ARB -- requirements
Module: ipg_tx_arb

Interface
REQ-001 Parameter DATA_W, default 64: width of one 64b/66b block payload and of each channel word.
REQ-002 Parameter HDR_W, default 2: sync header width.
REQ-003 Parameter NUM_CH, default 2, legal 1..8: number of IPG message channels.
REQ-004 Parameter FIFO_DEPTH, default 16, power of 2, 2..256: words per channel FIFO.
REQ-005 Parameter RR_EN, default 1: 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
REQ-006 Clocking: one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  single clock, all logic on rising edge.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 encoded_tx_hdr  in  HDR_W  sync header of the current MAC block.
REQ-010 encoded_tx_data  in  DATA_W  payload of the current MAC block.
REQ-011 ch_wr  in  NUM_CH  per-channel push strobe.
REQ-012 ch_data  in  NUM_CH*DATA_W  per-channel push word; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-013 proced_encoded_tx_hdr  out  HDR_W  registered output header.
REQ-014 proced_encoded_tx_data  out  DATA_W  registered output payload.
REQ-015 ch_full  out  NUM_CH  channel FIFO full, combinational from occupancy.
REQ-016 ch_empty  out  NUM_CH  channel FIFO empty.
REQ-017 ch_ovf  out  NUM_CH  sticky: push attempted while full and not simultaneously popped.
REQ-018 ins_cnt  out  32  count of inserted IPG words, wraps 0xFFFFFFFF -> 0.

Function
REQ-019 Idle block = hdr SYNC_CTRL (2'b01) and data == 64'h1E; any other block is a non-idle block.
REQ-020 Non-idle input block: output next cycle unchanged (hdr and data), no FIFO popped, arbiter state unchanged.
REQ-021 Idle input block and all FIFOs empty: idle block output unchanged next cycle.
REQ-022 Idle input block and at least one FIFO non-empty: grant exactly one channel, pop its head word, output hdr SYNC_CTRL with data = head word next cycle.
REQ-023 Latency input-to-output is exactly 1 cycle for all three cases; one output block per cycle, no stalls.
REQ-024 RR_EN=1: search starts at rr_ptr, wraps at NUM_CH-1 -> 0; after a grant to channel g, rr_ptr becomes (g+1) mod NUM_CH; no grant means rr_ptr held.
REQ-025 RR_EN=0: lowest-indexed non-empty channel wins; rr_ptr unused.
REQ-026 FIFO push while not full: word stored, visible at head no earlier than next cycle (no fall-through).
REQ-027 Push while full with simultaneous pop of the same channel: both accepted, occupancy unchanged.
REQ-028 Push while full without pop: word dropped, FIFO contents unchanged, ch_ovf[k] set until reset.
REQ-029 Pop occurs only on grant; a grant is never issued to an empty channel.
REQ-030 Push into empty FIFO in same cycle as an idle block: no insertion that cycle for that channel.
REQ-031 Occupancy counters are log2(FIFO_DEPTH)+1 bits; pointers log2(FIFO_DEPTH) bits, wrapping naturally.
REQ-032 ins_cnt increments by 1 on every cycle a grant is issued.

Reset
REQ-033 Reset outputs: proced_encoded_tx_hdr = 2'b01, proced_encoded_tx_data = 64'h1E, ch_full = 0, ch_empty = all ones, ch_ovf = 0, ins_cnt = 0.
REQ-034 Reset flushes all FIFOs (pointers and occupancy to 0) and sets rr_ptr = 0; reset mid-frame or mid-drain discards queued words with no partial output.
REQ-035 Pushes and input blocks presented during reset are ignored.

Structure
REQ-036 Shared package ipg_pkg holds SYNC_CTRL, SYNC_DATA, IDLE_BLOCK constants and the channel-index width function.
REQ-037 One sub-module ipg_chan_fifo (parametrised DATA_W, FIFO_DEPTH), instantiated NUM_CH times by generate; arbiter and output register live in ipg_tx_arb.

Verification
REQ-038 Pass-through: 10 SYNC_DATA blocks, FIFOs empty -> identical 10 blocks out, 1 cycle later, ins_cnt = 0.
REQ-039 Insertion: push 0xA5A5_0000_0000_0001 on ch0, then idle block -> output hdr 2'b01 data 0xA5A5_0000_0000_0001, ch_empty[0] = 1, ins_cnt = 1.
REQ-040 Round-robin: NUM_CH=2, 3 words each on ch0/ch1, 6 idles -> grant order 0,1,0,1,0,1; with RR_EN=0 -> 0,0,0,1,1,1.
REQ-041 Overflow: FIFO_DEPTH=4, 5 pushes to ch1 with no idles -> ch_full[1]=1, ch_ovf[1]=1, 4 words drained in order on later idles, 5th never appears.
REQ-042 Full push+pop: ch0 full, push 0x77 with idle input -> head output, occupancy stays 4, ch_ovf[0]=0, 0x77 emerges last.
REQ-043 Reset mid-drain: 3 words queued, assert reset one cycle during an idle -> next output 64'h1E, ch_empty all ones, ins_cnt = 0.
